// File: rtl/mem_responder.sv
// mem_responder: single-port memory behind a request/response handshake.
// A request (MAR, WE, MDR_IN) is captured on LDMAR in IDLE. It waits for
// LATENCY, performs the access, then pulses READY for one cycle in RESP.
// Addresses with bits above AW-1 set are out of range. An out-of-range write
// is dropped. An out-of-range read returns 0. Either case sets ERR.
// Optional feature macro: MEM_INDIRECT_EN adds the INDIRECT port and a second,
// pointer-chasing read stage (IND_WAIT, IND_ACCESS).
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   MAR, LDMAR, WE    - request address, strobe, write enable
//   MDR_IN            - write data
//   INDIRECT          - indirect-read qualifier (MEM_INDIRECT_EN only)
//   MDR               - read data register
//   READY, BUSY, ERR  - completion pulse, not-idle flag, out-of-range flag
module mem_responder #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 16,
    parameter int unsigned LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   MAR,
    input  logic          LDMAR,
    input  logic          WE,
    input  logic [DW-1:0] MDR_IN,
`ifdef MEM_INDIRECT_EN
    input  logic          INDIRECT,
`endif
    output logic [DW-1:0] MDR,
    output logic          READY,
    output logic          BUSY,
    output logic          ERR
);

    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT       = 3'd1;
    localparam logic [2:0] S_ACCESS     = 3'd2;
    localparam logic [2:0] S_RESP       = 3'd3;
`ifdef MEM_INDIRECT_EN
    localparam logic [2:0] S_IND_WAIT   = 3'd4;
    localparam logic [2:0] S_IND_ACCESS = 3'd5;
`endif

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] mdr_d;
    logic          ready_d, busy_d, err_d;
    logic          mem_we;
    logic [AW-1:0] idx;
    logic          oor;
    logic [DW-1:0] mem [DEPTH];
`ifdef MEM_INDIRECT_EN
    logic          ind_q, ind_d;
    logic [AW-1:0] ind_addr_q, ind_addr_d;
`endif

    assign idx = addr_q[AW-1:0];
    // Any address bit at or above AW means out of range.
    assign oor = (addr_q >> AW) != 16'd0;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        mdr_d   = MDR;
        err_d   = ERR;
        mem_we  = 1'b0;
`ifdef MEM_INDIRECT_EN
        ind_d      = ind_q;
        ind_addr_d = ind_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (LDMAR) begin
                    addr_d  = MAR;
                    we_d    = WE;
                    wdata_d = MDR_IN;
`ifdef MEM_INDIRECT_EN
                    ind_d   = INDIRECT;
`endif
                    cnt_d   = CW'(LATENCY);
                    state_d = S_WAIT;
                end
            end
            // Runs until the counter is exhausted, LATENCY+1 cycles, so READY
            // rises LATENCY+2 edges after the capture edge.
            S_WAIT: begin
                if (cnt_q == CW'(0)) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACCESS: begin
                err_d   = oor;
                state_d = S_RESP;
                if (we_q) begin
                    mem_we = ~oor;
                end else if (oor) begin
                    mdr_d = '0;
`ifdef MEM_INDIRECT_EN
                end else if (ind_q) begin
                    // The first read supplies the pointer for the second read.
                    ind_addr_d = mem[idx][AW-1:0];
                    cnt_d      = CW'(LATENCY);
                    state_d    = S_IND_WAIT;
`endif
                end else begin
                    mdr_d = mem[idx];
                end
            end
`ifdef MEM_INDIRECT_EN
            S_IND_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IND_ACCESS;
                end
            end
            S_IND_ACCESS: begin
                mdr_d   = mem[ind_addr_q];
                err_d   = 1'b0;
                state_d = S_RESP;
            end
`endif
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_RESP);
        busy_d  = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            MDR     <= '0;
            READY   <= 1'b0;
            BUSY    <= 1'b0;
            ERR     <= 1'b0;
`ifdef MEM_INDIRECT_EN
            ind_q      <= 1'b0;
            ind_addr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            MDR     <= mdr_d;
            READY   <= ready_d;
            BUSY    <= busy_d;
            ERR     <= err_d;
`ifdef MEM_INDIRECT_EN
            ind_q      <= ind_d;
            ind_addr_q <= ind_addr_d;
`endif
        end
    end

    // Storage array. It is not reset. A write commits only from ACCESS, so
    // a reset that lands earlier abandons the write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic checked against an associative-array memory model.
module tb_mem_responder;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 16;
    localparam int          LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   mar = '0;
    logic          ldmar = 1'b0;
    logic          we = 1'b0;
    logic          indirect = 1'b0;
    logic [DW-1:0] mdr_in = '0;
    logic [DW-1:0] mdr;
    logic          ready, busy, err;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] exp_mdr = '0;

    always #5 clk = ~clk;

    mem_responder #(.AW(AW), .DW(DW), .LATENCY(LAT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .MAR(mar),
        .LDMAR(ldmar),
        .WE(we),
        .MDR_IN(mdr_in),
`ifdef MEM_INDIRECT_EN
        .INDIRECT(indirect),
`endif
        .MDR(mdr),
        .READY(ready),
        .BUSY(busy),
        .ERR(err)
    );

    // Issue one request. lat is the number of edges from the capture edge to
    // the READY-high edge, or -1 on timeout. The task returns with the DUT in IDLE.
    task automatic do_req(input logic [15:0] a, input logic w, input logic [DW-1:0] d,
                          input logic ind, output int lat);
        @(negedge clk);
        mar = a; we = w; mdr_in = d; indirect = ind; ldmar = 1'b1;
        @(posedge clk);
        #1 ldmar = 1'b0;
        lat = 0;
        while (!ready && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!ready) lat = -1;
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #1;
        tests++; if (mdr !== '0)  begin fails++; $display("FAIL reset_mdr got %h exp 0", mdr); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (err !== 1'b0)  begin fails++; $display("FAIL reset_err got %b exp 0", err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int lat;
        do_req(16'h0005, 1'b1, 16'h1234, 1'b0, lat);
        ref_mem[5] = 16'h1234;
        tests++; if (lat !== LAT + 2) begin fails++; $display("FAIL wr_latency got %0d exp %0d", lat, LAT + 2); end
        tests++; if (mdr !== 16'h0000) begin fails++; $display("FAIL wr_mdr_hold got %h exp 0000", mdr); end
        do_req(16'h0005, 1'b0, 16'h0000, 1'b0, lat);
        exp_mdr = 16'h1234;
        tests++; if (lat !== LAT + 2) begin fails++; $display("FAIL rd_latency got %0d exp %0d", lat, LAT + 2); end
        tests++; if (mdr !== 16'h1234) begin fails++; $display("FAIL rd_data got %h exp 1234", mdr); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rd_err got %b exp 0", err); end
    endtask

    task automatic test_out_of_range();
        int lat;
        do_req(16'h0000, 1'b1, 16'h5A5A, 1'b0, lat);
        ref_mem[0] = 16'h5A5A;
        do_req(16'h0100, 1'b0, 16'h0000, 1'b0, lat);
        exp_mdr = '0;
        tests++; if (mdr !== 16'h0000) begin fails++; $display("FAIL oor_rd_data got %h exp 0000", mdr); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL oor_rd_err got %b exp 1", err); end
        tests++; if (lat !== LAT + 2) begin fails++; $display("FAIL oor_latency got %0d exp %0d", lat, LAT + 2); end
        do_req(16'h0100, 1'b1, 16'h1111, 1'b0, lat);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL oor_wr_err got %b exp 1", err); end
        tests++; if (mdr !== 16'h0000) begin fails++; $display("FAIL oor_wr_mdr got %h exp 0000", mdr); end
        do_req(16'h0000, 1'b0, 16'h0000, 1'b0, lat);
        exp_mdr = ref_mem[0];
        tests++; if (mdr !== exp_mdr) begin fails++; $display("FAIL oor_wr_dropped got %h exp %h", mdr, exp_mdr); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL oor_err_clear got %b exp 0", err); end
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] a;
        logic [DW-1:0] d;
        logic w;
        logic oor;
        for (int i = 0; i < 16; i++) begin
            d = DW'($urandom_range(0, 65535));
            do_req(16'h0020 + 16'(i), 1'b1, d, 1'b0, lat);
            ref_mem[32 + i] = d;
            tests++; if (err !== 1'b0) begin fails++; $display("FAIL rnd_fill_err addr %0d got %b exp 0", 32 + i, err); end
        end
        for (int i = 0; i < 40; i++) begin
            oor = ($urandom_range(0, 9) < 2);
            a = oor ? 16'(16'h0100 + 16'($urandom_range(0, 16'hFEFF))) : 16'(16'h0020 + 16'($urandom_range(0, 15)));
            w = 1'($urandom_range(0, 1));
            d = DW'($urandom_range(0, 65535));
            do_req(a, w, d, 1'b0, lat);
            if (!oor && w) ref_mem[int'(a)] = d;
            if (!w) exp_mdr = oor ? '0 : ref_mem[int'(a)];
            tests++; if (lat !== LAT + 2) begin fails++; $display("FAIL rnd_latency #%0d got %0d exp %0d", i, lat, LAT + 2); end
            tests++; if (mdr !== exp_mdr) begin fails++; $display("FAIL rnd_mdr #%0d addr %h we %b got %h exp %h", i, a, w, mdr, exp_mdr); end
            tests++; if (err !== oor) begin fails++; $display("FAIL rnd_err #%0d addr %h got %b exp %b", i, a, err, oor); end
        end
    endtask

    task automatic test_ldmar_held();
        int next_free = 0;
        int cap = -100;
        int pulses = 0;
        int exp_pulses = 0;
        logic exp_busy, exp_ready;
        @(negedge clk);
        mar = 16'h0020; we = 1'b0; indirect = 1'b0; ldmar = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 9) ldmar = 1'b0;
            // Each accepted request keeps the block away from IDLE for LAT+4 edges.
            if (k <= 9 && k >= next_free) begin
                cap = k;
                next_free = k + LAT + 4;
                exp_pulses++;
            end
            exp_busy  = (k >= cap) && (k <= cap + LAT + 2);
            exp_ready = (k == cap + LAT + 2);
            if (ready) pulses++;
            tests++; if (busy !== exp_busy) begin fails++; $display("FAIL held_busy edge %0d got %b exp %b", k, busy, exp_busy); end
            tests++; if (ready !== exp_ready) begin fails++; $display("FAIL held_ready edge %0d got %b exp %b", k, ready, exp_ready); end
        end
        tests++; if (pulses !== exp_pulses) begin fails++; $display("FAIL held_pulses got %0d exp %0d", pulses, exp_pulses); end
        exp_mdr = ref_mem[32];
        tests++; if (mdr !== exp_mdr) begin fails++; $display("FAIL held_mdr got %h exp %h", mdr, exp_mdr); end
    endtask

    task automatic test_reset_mid();
        int lat;
        do_req(16'h0010, 1'b1, 16'hBEEF, 1'b0, lat);
        do_req(16'h0010, 1'b0, 16'h0000, 1'b0, lat);
        tests++; if (mdr !== 16'hBEEF) begin fails++; $display("FAIL rstmid_pre got %h exp beef", mdr); end
        @(negedge clk);
        mar = 16'h0010; we = 1'b1; mdr_in = 16'h0000; ldmar = 1'b1;
        @(posedge clk);
        #1 ldmar = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_wait got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        tests++; if (mdr !== '0) begin fails++; $display("FAIL rstmid_mdr got %h exp 0", mdr); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready got %b exp 0", ready); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        do_req(16'h0010, 1'b0, 16'h0000, 1'b0, lat);
        exp_mdr = 16'hBEEF;
        tests++; if (mdr !== 16'hBEEF) begin fails++; $display("FAIL rstmid_no_commit got %h exp beef", mdr); end
        tests++; if (lat !== LAT + 2) begin fails++; $display("FAIL rstmid_latency got %0d exp %0d", lat, LAT + 2); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int extra = 0;
        int lat;
        @(negedge clk);
        mar = 16'h0020; we = 1'b0; indirect = 1'b0; ldmar = 1'b1;
        @(posedge clk);
        #1 ldmar = 1'b0;
        while (!ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++; if (n !== LAT + 2) begin fails++; $display("FAIL b2b_first_latency got %0d exp %0d", n, LAT + 2); end
        mar = 16'h0021; ldmar = 1'b1;
        @(posedge clk);
        #1 ldmar = 1'b0;
        exp_mdr = ref_mem[32];
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_resp_ignored got busy %b exp 0", busy); end
        tests++; if (mdr !== exp_mdr) begin fails++; $display("FAIL b2b_first_mdr got %h exp %h", mdr, exp_mdr); end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (ready || busy) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL b2b_no_activity got %0d exp 0", extra); end
        do_req(16'h0021, 1'b0, 16'h0000, 1'b0, lat);
        exp_mdr = ref_mem[33];
        tests++; if (mdr !== exp_mdr) begin fails++; $display("FAIL b2b_reassert got %h exp %h", mdr, exp_mdr); end
        tests++; if (lat !== LAT + 2) begin fails++; $display("FAIL b2b_reassert_lat got %0d exp %0d", lat, LAT + 2); end
    endtask

`ifdef MEM_INDIRECT_EN
    task automatic test_indirect();
        int lat;
        do_req(16'h0003, 1'b1, 16'h0007, 1'b0, lat);
        do_req(16'h0007, 1'b1, 16'hCAFE, 1'b0, lat);
        do_req(16'h0003, 1'b0, 16'h0000, 1'b1, lat);
        tests++; if (mdr !== 16'hCAFE) begin fails++; $display("FAIL ind_data got %h exp cafe", mdr); end
        tests++; if (lat !== 2 * LAT + 3) begin fails++; $display("FAIL ind_latency got %0d exp %0d", lat, 2 * LAT + 3); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL ind_err got %b exp 0", err); end
        do_req(16'h0203, 1'b0, 16'h0000, 1'b1, lat);
        tests++; if (mdr !== 16'h0000) begin fails++; $display("FAIL ind_oor_data got %h exp 0000", mdr); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL ind_oor_err got %b exp 1", err); end
        tests++; if (lat !== LAT + 2) begin fails++; $display("FAIL ind_oor_latency got %0d exp %0d", lat, LAT + 2); end
        do_req(16'h0030, 1'b1, 16'h0003, 1'b1, lat);
        tests++; if (lat !== LAT + 2) begin fails++; $display("FAIL ind_wr_latency got %0d exp %0d", lat, LAT + 2); end
        do_req(16'h0030, 1'b0, 16'h0000, 1'b0, lat);
        tests++; if (mdr !== 16'h0003) begin fails++; $display("FAIL ind_wr_direct got %h exp 0003", mdr); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_random();
        test_ldmar_held();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_INDIRECT_EN
        test_indirect();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
